// File: rtl/note_enable_ctrl_if.sv
// Note-enable bus: raw keys and sample strobe in, per-note enables and voice status out.
// Optional macro SUSTAIN_EN adds the sustain_in pedal input.
interface note_enable_ctrl_if #(
    parameter int unsigned NUM_KEYS = 12
);
    logic [NUM_KEYS-1:0] keys_in;
    logic                sample_tick;
    logic [NUM_KEYS-1:0] sample_enable;
    logic [3:0]          active_count;
    logic                voice_full;
`ifdef SUSTAIN_EN
    logic                sustain_in;

    modport master (
        output keys_in, sample_tick, sustain_in,
        input  sample_enable, active_count, voice_full
    );
    modport slave (
        input  keys_in, sample_tick, sustain_in,
        output sample_enable, active_count, voice_full
    );
`else
    modport master (
        output keys_in, sample_tick,
        input  sample_enable, active_count, voice_full
    );
    modport slave (
        input  keys_in, sample_tick,
        output sample_enable, active_count, voice_full
    );
`endif
endinterface

// File: rtl/note_enable_ctrl.sv
// Note enable controller: synchronises and debounces the note keys, then allocates up to
// MAX_VOICES voices (lowest key first, no stealing) and updates the enables only on
// sample_tick. Optional macro SUSTAIN_EN adds a debounced sustain pedal that keeps
// released notes sounding until the pedal is let go.
module note_enable_ctrl #(
    parameter int unsigned NUM_KEYS        = 12,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned CNT_W           = 17,
    parameter int unsigned MAX_VOICES      = 4
) (
    input logic                clk,
    input logic                n_rst,   // active-high asynchronous reset
    note_enable_ctrl_if.slave  bus_io
);

`ifdef SUSTAIN_EN
    localparam int unsigned NumIn = NUM_KEYS + 1;   // sustain rides on the top bit
`else
    localparam int unsigned NumIn = NUM_KEYS;
`endif
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       MaxVoices = 4'(MAX_VOICES);

    logic [NumIn-1:0]    raw_in;
    logic [NumIn-1:0]    sync1_q, sync2_q;
    logic [NumIn-1:0]    stable_q, stable_d;
    logic [CNT_W-1:0]    cnt_q [NumIn];
    logic [CNT_W-1:0]    cnt_d [NumIn];
    logic [NUM_KEYS-1:0] key_stable;
    logic [NUM_KEYS-1:0] held, fresh, enable_d;
    logic [3:0]          voices_d;
    logic [NUM_KEYS-1:0] sample_enable_q;
    logic [3:0]          active_count_q;
    logic                voice_full_q;

`ifdef SUSTAIN_EN
    assign raw_in = {bus_io.sustain_in, bus_io.keys_in};
`else
    assign raw_in = bus_io.keys_in;
`endif
    assign key_stable = stable_q[NUM_KEYS-1:0];

    // Two-flop synchroniser for every raw button
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: accept a new level only after it has held DEBOUNCE_CYCLES cycles
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NumIn; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state: accepted key levels and per-key stability counters
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            stable_q <= '0;
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Voice allocation: keep held notes, then grant new presses lowest index first
    always_comb begin
        held = sample_enable_q & key_stable;
`ifdef SUSTAIN_EN
        if (stable_q[NUM_KEYS]) begin
            held = sample_enable_q;
        end
`endif
        fresh    = key_stable & ~sample_enable_q;
        voices_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            voices_d = voices_d + {3'b000, held[i]};
        end
        enable_d = held;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (fresh[i] && (voices_d < MaxVoices)) begin
                enable_d[i] = 1'b1;
                voices_d    = voices_d + 4'd1;
            end
        end
    end

    // Enables and voice status change only on a sample tick
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            sample_enable_q <= '0;
            active_count_q  <= '0;
            voice_full_q    <= 1'b0;
        end else if (bus_io.sample_tick) begin
            sample_enable_q <= enable_d;
            active_count_q  <= voices_d;
            voice_full_q    <= (voices_d == MaxVoices);
        end
    end

    assign bus_io.sample_enable = sample_enable_q;
    assign bus_io.active_count  = active_count_q;
    assign bus_io.voice_full    = voice_full_q;

endmodule

// File: doc/note_enable_ctrl.md
Name: note_enable_ctrl

Overview:
Turns the 12 raw note push-buttons pb[11:0] into the registered sample_enable[11:0] vector that the signal mixer uses to select which waveshaper samples are summed. Each key is synchronised and debounced. A polyphony cap is enforced, and enables change only on sample-rate ticks (the sample_now strobe from sample_rate_clkdiv) so notes never start or stop in the middle of a sample.

Parameters:
NUM_KEYS, 12, number of note keys/voices
DEBOUNCE_CYCLES, 100000, cycles a key must be stable before its state is accepted (10 ms at 10 MHz)
CNT_W, 17, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
MAX_VOICES, 4, maximum simultaneously enabled notes (1..NUM_KEYS)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous, active-high reset (1 = reset)
keys_in  input  NUM_KEYS  raw asynchronous push-buttons, 1 = pressed
sample_tick  input  1  one-cycle strobe, sample_now from sample_rate_clkdiv
sample_enable  output  NUM_KEYS  registered per-note enable to signal_mixer
active_count  output  4  registered popcount of sample_enable
voice_full  output  1  registered; 1 when active_count == MAX_VOICES

Behaviour:
- Reset (async assert, sync release): sync flops, stable key state, debounce counters, sample_enable, active_count and voice_full all go to 0.
- Sync: each keys_in bit passes through a 2-flop synchroniser, giving sync[i].
- Debounce, per key, independent counter cnt[i]:
  - sync[i] == stable[i] -> cnt[i] <= 0.
  - sync[i] != stable[i] and cnt[i] < DEBOUNCE_CYCLES-1 -> cnt[i] increments.
  - sync[i] != stable[i] and cnt[i] == DEBOUNCE_CYCLES-1 -> stable[i] <= sync[i], cnt[i] <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count; stable[i] is unchanged.
- Latency: a clean edge on keys_in reaches stable[] 2 + DEBOUNCE_CYCLES cycles later. It reaches sample_enable at the first sample_tick after that, registered one cycle later.
- Allocation is combinational next-state, applied only on a clk edge with sample_tick = 1:
  - held = sample_enable & stable. Held notes keep their voice; there is no stealing.
  - Keys that are newly pressed (stable & ~sample_enable) are added in ascending index order (key 0 first) while popcount < MAX_VOICES. The remaining new keys are ignored for this tick.
  - An ignored key stays pending while still pressed and is granted at a later tick once a voice frees.
  - A released key (stable = 0) is removed at the same tick it is noticed.
  - A release and a new press on the same tick: the freed voice is reusable by that press within the same tick.
- With sample_tick = 0, sample_enable, active_count and voice_full hold.
- active_count and voice_full update in the same cycle as sample_enable. They are always consistent with it and never exceed MAX_VOICES.
- Reset mid-operation: everything clears immediately. After release a held key must re-debounce, i.e. wait the full DEBOUNCE_CYCLES, before it is re-enabled.
- Widths: popcount is computed 4 bits wide. NUM_KEYS <= 15 is required.

Optional Feature:
SUSTAIN_EN
- Defined:
  - Adds input port sustain_in (1 bit; pb[16] at top level), synchronised and debounced exactly like a key.
  - While debounced sustain = 1, released keys keep their voice, so held = sample_enable.
  - New presses are still allocated within MAX_VOICES.
  - On sustain release, the next sample_tick drops every note whose stable bit is 0.
- Not defined: no sustain_in port; behaviour exactly as above.

Test Plan (DEBOUNCE_CYCLES=8, MAX_VOICES=4, sample_tick every 16 cycles):
- Reset: hold n_rst=1 with keys_in=12'hFFF -> sample_enable=0, active_count=0, voice_full=0. Release reset -> enables appear only after 2+8 cycles plus the next tick.
- Bounce: toggle keys_in[3] with 3-cycle pulses for 40 cycles, then hold 1 -> sample_enable[3] stays 0 during bouncing and rises at the first tick >= 10 cycles after the final edge.
- Polyphony cap: press keys 0,2,5,7,9,11 together -> after a tick, sample_enable=12'h0A5, active_count=4, voice_full=1.
- Pending grant: from the previous state, release key 2 -> at the next tick sample_enable=12'h2A1 (2 dropped, 9 granted), active_count=4.
- Tick gating: a key debounced 1 cycle after a tick -> sample_enable unchanged for 15 cycles, then updates the cycle after the next tick.
- SUSTAIN_EN: press keys 1,4, assert sustain, release both -> sample_enable stays 12'h012. Drop sustain -> 12'h000 at the next tick.
